pc_gen: RTL and testbench

Parametrised program-counter generator for the MIPS pipeline fetch stage. It holds the architectural PC register and computes the next PC from sequential, branch (six compare modes), jump, register-jump, exception and exception-return sources. It supports stall and an optional branch delay slot, and keeps the EPC/BD exception state. It feeds instruction memory and the register-file link-address path.

---
 rtl/pc_gen_pkg.sv | 30 +++
 rtl/pc_gen_if.sv | 31 +++
 rtl/pc_gen_br_cmp_n.sv | 32 +++
 rtl/pc_gen.sv | 154 +++++++++++++++
 tb/tb_pc_gen.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_gen_pkg.sv
// Shared encodings for the pc_gen fetch-stage program counter:
// next-PC operation classes, branch compare modes and sequencer states.
package pc_gen_pkg;

  localparam int NPC_OP_W = 3;
  localparam int BR_OP_W  = 3;

  typedef enum logic [NPC_OP_W-1:0] {
    PLUS4  = 3'd0,
    BRANCH = 3'd1,
    JUMP   = 3'd2,
    JR     = 3'd3,
    ERET   = 3'd4
  } npc_op_e;

  typedef enum logic [BR_OP_W-1:0] {
    BEQ  = 3'd0,
    BNE  = 3'd1,
    BLEZ = 3'd2,
    BGTZ = 3'd3,
    BLTZ = 3'd4,
    BGEZ = 3'd5
  } br_op_e;

  typedef enum logic {
    SEQ   = 1'b0,
    DSLOT = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pc_gen_if.sv
// Control/operand bundle between the decode side (master) and pc_gen (slave).
interface pc_gen_if #(
  parameter int WIDTH = 32
);
  import pc_gen_pkg::*;

  logic                stall;
  logic [NPC_OP_W-1:0] op;
  logic [BR_OP_W-1:0]  br_op;
  logic [WIDTH-1:0]    rs;
  logic [WIDTH-1:0]    rt;
  logic [25:0]         imm26;
  logic                exc_req;
  logic [WIDTH-1:0]    pc;
  logic [WIDTH-1:0]    npc;
  logic [WIDTH-1:0]    laddr;
  logic                taken;
  logic [WIDTH-1:0]    epc;
  logic                bd;

  modport master (
    output stall, op, br_op, rs, rt, imm26, exc_req,
    input  pc, npc, laddr, taken, epc, bd
  );

  modport slave (
    input  stall, op, br_op, rs, rt, imm26, exc_req,
    output pc, npc, laddr, taken, epc, bd
  );

endinterface

// File: rtl/pc_gen_br_cmp_n.sv
// br_cmp_n: combinational branch condition evaluator; sign-based modes
// test rs against zero as a two's-complement value.
module br_cmp_n
  import pc_gen_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [BR_OP_W-1:0] br_op,
  input  logic [WIDTH-1:0]   rs,
  input  logic [WIDTH-1:0]   rt,
  output logic               taken
);

  logic rs_neg;
  logic rs_zero;

  always_comb begin
    rs_neg  = rs[WIDTH-1];
    rs_zero = (rs == '0);
    taken   = 1'b0;
    case (br_op)
      BEQ:     taken = (rs == rt);
      BNE:     taken = (rs != rt);
      BLEZ:    taken = rs_neg | rs_zero;
      BGTZ:    taken = ~rs_neg & ~rs_zero;
      BLTZ:    taken = rs_neg;
      BGEZ:    taken = ~rs_neg;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: MIPS fetch-stage PC register with branch/jump/JR/exception/ERET sources.
// Define PC_GEN_DELAY_SLOT_EN to build with a one-instruction branch delay slot.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int          WIDTH    = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC  = 32'h0000_4180
) (
  input  logic    clk,
  input  logic    rst_n,
  pc_gen_if.slave bus
);

  localparam logic [WIDTH-1:0] RESET_PC_W = WIDTH'(RESET_PC);
  localparam logic [WIDTH-1:0] EXC_VEC_W  = WIDTH'(EXC_VEC);
  localparam logic [WIDTH-1:0] FOUR       = WIDTH'(4);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic [WIDTH-1:0] pc_plus4, br_target, j_target, xfer_target;
  logic [WIDTH-1:0] npc_c;
  logic             taken_c;
  logic             cmp_taken;
  logic             xfer_taken;

  br_cmp_n #(.WIDTH(WIDTH)) u_br_cmp (
    .br_op (bus.br_op),
    .rs    (bus.rs),
    .rt    (bus.rt),
    .taken (cmp_taken)
  );

  always_comb begin : target_sel
    pc_plus4    = pc_q + FOUR;
    br_target   = pc_plus4 + {{(WIDTH-18){bus.imm26[15]}}, bus.imm26[15:0], 2'b00};
    j_target    = {pc_q[WIDTH-1:28], bus.imm26, 2'b00};
    xfer_taken  = 1'b0;
    xfer_target = pc_plus4;
    case (bus.op)
      BRANCH: begin
        xfer_taken  = cmp_taken;
        xfer_target = br_target;
      end
      JUMP: begin
        xfer_taken  = 1'b1;
        xfer_target = j_target;
      end
      JR: begin
        xfer_taken  = 1'b1;
        xfer_target = bus.rs;
      end
      ERET: begin
        xfer_taken  = 1'b1;
        xfer_target = epc_q;
      end
      default: ;
    endcase
  end

`ifdef PC_GEN_DELAY_SLOT_EN
  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             bd_q, bd_d;

  // A redirect in SEQ parks its target and lets the slot instruction issue first.
  always_comb begin : next_state
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    bd_d    = bd_q;
    pend_d  = pend_q;
    taken_c = 1'b0;
    npc_c   = pc_plus4;
    if (state_q == DSLOT) begin
      npc_c = pend_q;
    end else begin
      taken_c = xfer_taken;
    end

    if (bus.exc_req) begin
      pc_d    = EXC_VEC_W;
      state_d = SEQ;
      if (state_q == DSLOT) begin
        epc_d = pc_q - FOUR;
        bd_d  = 1'b1;
      end else begin
        epc_d = pc_q;
        bd_d  = 1'b0;
      end
    end else if (!bus.stall) begin
      pc_d = npc_c;
      if (state_q == DSLOT) begin
        state_d = SEQ;
      end else begin
        if (xfer_taken) begin
          pend_d  = xfer_target;
          state_d = DSLOT;
        end
        if (bus.op == ERET) begin
          bd_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : slot_regs
    if (!rst_n) begin
      state_q <= SEQ;
      pend_q  <= '0;
      bd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      bd_q    <= bd_d;
    end
  end

  assign bus.laddr = pc_q + WIDTH'(8);
  assign bus.bd    = bd_q;
`else
  always_comb begin : next_pc
    pc_d    = pc_q;
    epc_d   = epc_q;
    taken_c = xfer_taken;
    npc_c   = xfer_taken ? xfer_target : pc_plus4;
    if (bus.exc_req) begin
      pc_d  = EXC_VEC_W;
      epc_d = pc_q;
    end else if (!bus.stall) begin
      pc_d = npc_c;
    end
  end

  assign bus.laddr = pc_plus4;
  assign bus.bd    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin : pc_regs
    if (!rst_n) begin
      pc_q  <= RESET_PC_W;
      epc_q <= '0;
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
    end
  end

  assign bus.pc    = pc_q;
  assign bus.npc   = npc_c;
  assign bus.taken = taken_c;
  assign bus.epc   = epc_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: directed fetch scenarios plus random traffic
// against an arithmetic reference model; honours PC_GEN_DELAY_SLOT_EN.
module tb_pc_gen;
  import pc_gen_pkg::*;

  localparam int          W        = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC  = 32'h0000_4180;
`ifdef PC_GEN_DELAY_SLOT_EN
  localparam bit SLOT_EN = 1'b1;
`else
  localparam bit SLOT_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  pc_gen_if #(.WIDTH(W)) bus ();

  pc_gen #(.WIDTH(W), .RESET_PC(RESET_PC), .EXC_VEC(EXC_VEC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] laddr;
    logic [31:0] epc;
    logic        taken;
    logic        bd;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // Reference model: architectural PC, EPC/BD and an optional parked redirect.
  logic [31:0] m_pc   = RESET_PC;
  logic [31:0] m_epc  = '0;
  logic [31:0] m_pend = '0;
  bit          m_bd   = 1'b0;
  bit          m_slot = 1'b0;

  task automatic checkOutput(input string name, input int c,
                             input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d got=%h expected=%h", name, c, got, exp);
    end
  endtask

  task automatic modelTransfer(input logic [2:0] op, input logic [2:0] br,
                               input logic [31:0] rs, input logic [31:0] rt,
                               input logic [25:0] imm,
                               output bit tk, output logic [31:0] tgt);
    int                 srs;
    int                 off;
    logic signed [15:0] imm16;
    srs   = rs;
    imm16 = imm[15:0];
    off   = imm16;
    tk    = 1'b0;
    tgt   = m_pc + 32'd4;
    case (op)
      BRANCH: begin
        case (br)
          BEQ:     tk = (rs == rt);
          BNE:     tk = (rs != rt);
          BLEZ:    tk = (srs <= 0);
          BGTZ:    tk = (srs > 0);
          BLTZ:    tk = (srs < 0);
          BGEZ:    tk = (srs >= 0);
          default: tk = 1'b0;
        endcase
        tgt = m_pc + 32'd4 + 32'(off * 4);
      end
      JUMP: begin
        tk  = 1'b1;
        tgt = {m_pc[31:28], imm, 2'b00};
      end
      JR: begin
        tk  = 1'b1;
        tgt = rs;
      end
      ERET: begin
        tk  = 1'b1;
        tgt = m_epc;
      end
      default: ;
    endcase
  endtask

  // Drives one cycle of inputs at the falling edge, queues what the DUT must
  // show for this cycle, then advances the model past the next rising edge.
  task automatic applyStimulus(input bit rst, input logic [2:0] op, input logic [2:0] br,
                               input logic [31:0] rs, input logic [31:0] rt,
                               input logic [25:0] imm, input bit exc, input bit stl);
    exp_t        e;
    bit          tk;
    logic [31:0] tgt;
    @(negedge clk);
    rst_n       = !rst;
    bus.op      = op;
    bus.br_op   = br;
    bus.rs      = rs;
    bus.rt      = rt;
    bus.imm26   = imm;
    bus.exc_req = exc;
    bus.stall   = stl;
    cyc++;
    if (rst) begin
      m_pc   = RESET_PC;
      m_epc  = '0;
      m_bd   = 1'b0;
      m_slot = 1'b0;
    end
    modelTransfer(op, br, rs, rt, imm, tk, tgt);
    e.cyc   = cyc;
    e.pc    = m_pc;
    e.epc   = m_epc;
    e.bd    = m_bd;
    e.laddr = m_pc + (SLOT_EN ? 32'd8 : 32'd4);
    if (SLOT_EN && m_slot) begin
      e.taken = 1'b0;
      e.npc   = m_pend;
    end else begin
      e.taken = tk;
      e.npc   = (tk && !SLOT_EN) ? tgt : m_pc + 32'd4;
    end
    sb.push_back(e);

    if (rst) begin
      m_pc = RESET_PC;
    end else if (exc) begin
      m_epc  = m_slot ? m_pc - 32'd4 : m_pc;
      m_bd   = m_slot;
      m_slot = 1'b0;
      m_pc   = EXC_VEC;
    end else if (!stl) begin
      if (m_slot) begin
        m_pc   = m_pend;
        m_slot = 1'b0;
      end else begin
        if (op == ERET) m_bd = 1'b0;
        if (tk && SLOT_EN) begin
          m_pend = tgt;
          m_slot = 1'b1;
          m_pc   = m_pc + 32'd4;
        end else begin
          m_pc = tk ? tgt : m_pc + 32'd4;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, PLUS4, BEQ, '0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, PLUS4, BEQ, '0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("pc",    e.cyc, bus.pc,          e.pc);
        checkOutput("npc",   e.cyc, bus.npc,         e.npc);
        checkOutput("taken", e.cyc, 32'(bus.taken),  32'(e.taken));
        checkOutput("laddr", e.cyc, bus.laddr,       e.laddr);
        checkOutput("epc",   e.cyc, bus.epc,         e.epc);
        checkOutput("bd",    e.cyc, 32'(bus.bd),     32'(e.bd));
      end
    end
  end

  initial begin : stimulus
    int budget;
    bus.stall   = 1'b0;
    bus.op      = '0;
    bus.br_op   = '0;
    bus.rs      = '0;
    bus.rt      = '0;
    bus.imm26   = '0;
    bus.exc_req = 1'b0;

    doReset();
    idle(4);

    doReset();
    applyStimulus(1'b0, BRANCH, BEQ, 32'd5, 32'd5, 26'h0003, 1'b0, 1'b0);
    idle(3);

    applyStimulus(1'b0, BRANCH, BLTZ, 32'hFFFF_FFFF, 32'd0, 26'h0010, 1'b0, 1'b0);
    idle(2);
    applyStimulus(1'b0, BRANCH, BGTZ, 32'd0, 32'd0, 26'h0010, 1'b0, 1'b0);
    idle(2);
    applyStimulus(1'b0, BRANCH, BNE, 32'd7, 32'd7, 26'h3FF_FFFC, 1'b0, 1'b0);
    applyStimulus(1'b0, BRANCH, BNE, 32'd7, 32'd8, 26'h3FF_FFFC, 1'b0, 1'b0);
    idle(2);

    doReset();
    applyStimulus(1'b0, JR, BEQ, 32'h3400, '0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, JR, BEQ, 32'h3400, '0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, JR, BEQ, 32'h3400, '0, '0, 1'b0, 1'b0);
    idle(2);

    doReset();
    idle(2);
    applyStimulus(1'b0, PLUS4, BEQ, '0, '0, '0, 1'b1, 1'b1);
    applyStimulus(1'b0, ERET, BEQ, '0, '0, '0, 1'b0, 1'b0);
    idle(3);

    applyStimulus(1'b0, 3'd7, BEQ, 32'd1, 32'd1, 26'h0003, 1'b0, 1'b0);
    applyStimulus(1'b0, BRANCH, 3'd6, 32'd1, 32'd1, 26'h0003, 1'b0, 1'b0);
    applyStimulus(1'b0, JUMP, BEQ, '0, '0, 26'h2A_5555, 1'b0, 1'b0);
    idle(2);

`ifdef PC_GEN_DELAY_SLOT_EN
    doReset();
    applyStimulus(1'b0, BRANCH, BEQ, 32'd5, 32'd5, 26'h0003, 1'b0, 1'b0);
    applyStimulus(1'b0, PLUS4, BEQ, '0, '0, '0, 1'b1, 1'b0);
    idle(3);

    doReset();
    applyStimulus(1'b0, JUMP, BEQ, '0, '0, 26'h000_1200, 1'b0, 1'b0);
    applyStimulus(1'b0, JR, BEQ, 32'h5000, '0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, JR, BEQ, 32'h5000, '0, '0, 1'b0, 1'b0);
    idle(2);

    doReset();
    applyStimulus(1'b0, BRANCH, BEQ, 32'd5, 32'd5, 26'h0003, 1'b0, 1'b0);
    doReset();
    idle(2);
`endif

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  o;
      logic [2:0]  bo;
      bit          r;
      bit          x;
      bit          s;
      o  = 3'($urandom_range(0, 7));
      bo = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 4)) - 32'd2;
      b  = ($urandom_range(0, 2) == 0) ? a : 32'($urandom);
      x  = ($urandom_range(0, 19) == 0);
      s  = ($urandom_range(0, 4) == 0);
      r  = ($urandom_range(0, 99) == 0);
      applyStimulus(r, o, bo, a, b, 26'($urandom), x, s);
    end

    budget = 20;
    while (sb.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    #3;
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain pending=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
